uart_tx_serializer: RTL and testbench

Data-path companion to the UART transmit control FSM. Captures a parallel byte when a transmission is requested, presents it LSB-first on `ser_data` one bit per enabled cycle, signals `ser_done` on the last data bit, and holds the frame's parity bit for the parity slot. It sits directly downstream of the FSM's `ser_en` output and upstream of the FSM's `ser_done` input, and it feeds the output bit mux.

---
 rtl/uart_pkg.sv | 14 +
 rtl/uart_tx_serializer_if.sv | 37 +++
 rtl/parity_calc.sv | 10 +
 rtl/uart_tx_serializer.sv | 72 +++++++
 tb/tb_uart_tx_serializer.sv | 143 ++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: payload width, parity encodings, counter sizing.
package uart_pkg;

  localparam int UART_DATA_WIDTH = 8;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // Counter must reach DATA_WIDTH itself, which marks the done state.
  function automatic int cnt_width(input int dw);
    return $clog2(dw + 1);
  endfunction

endpackage

// File: rtl/uart_tx_serializer_if.sv
// Handshake bundle between TX control FSM and the TX serializer.
import uart_pkg::*;

interface uart_tx_serializer_if #(
  parameter int DATA_WIDTH = UART_DATA_WIDTH
);
  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  DATA_VALID;
  logic                  Busy;
  logic                  ser_en;
  logic                  PAR_TYP;
  logic                  ser_data;
  logic                  ser_done;
  logic                  par_bit;

  modport master (
    output P_DATA,
    output DATA_VALID,
    output Busy,
    output ser_en,
    output PAR_TYP,
    input  ser_data,
    input  ser_done,
    input  par_bit
  );

  modport slave (
    input  P_DATA,
    input  DATA_VALID,
    input  Busy,
    input  ser_en,
    input  PAR_TYP,
    output ser_data,
    output ser_done,
    output par_bit
  );
endinterface

// File: rtl/parity_calc.sv
// Combinational parity: XOR-reduce of data folded with parity type.
module parity_calc #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] data,
  input  logic             par_typ,
  output logic             par
);
  assign par = (^data) ^ par_typ;
endmodule

// File: rtl/uart_tx_serializer.sv
// UART TX serializer: byte capture, LSB-first shift, done and parity hold.
// Parity register built only when UART_TX_PARITY_EN is defined.
import uart_pkg::*;

module uart_tx_serializer #(
  parameter int DATA_WIDTH = UART_DATA_WIDTH
) (
  input logic               CLK,
  input logic               RST,
  uart_tx_serializer_if.slave bus
);
  localparam int CW = cnt_width(DATA_WIDTH);

  localparam logic [CW-1:0] CNT_LOADED = '0;
  localparam logic [CW-1:0] CNT_DONE   = CW'(DATA_WIDTH);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);

  logic [DATA_WIDTH-1:0] shift_reg;
  logic [CW-1:0]         bit_cnt;
  logic                  capture;

  assign capture = bus.DATA_VALID && !bus.Busy && !bus.ser_en;

  // Count 0 is the start-bit slot: consume the enable, keep bit 0 parked.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      shift_reg <= '0;
      bit_cnt   <= CNT_DONE;
    end else if (capture) begin
      shift_reg <= bus.P_DATA;
      bit_cnt   <= CNT_LOADED;
    end else if (bus.ser_en) begin
      if (bit_cnt == CNT_LOADED) begin
        bit_cnt <= CNT_ONE;
      end else if (bit_cnt < CNT_DONE) begin
        shift_reg <= {1'b0, shift_reg[DATA_WIDTH-1:1]};
        bit_cnt   <= bit_cnt + CNT_ONE;
      end
    end
  end

  assign bus.ser_data = shift_reg[0];
  assign bus.ser_done = (bit_cnt == CNT_DONE);

`ifdef UART_TX_PARITY_EN
  logic par_nxt;
  logic par_q;

  parity_calc #(
    .WIDTH (DATA_WIDTH)
  ) u_parity_calc (
    .data    (bus.P_DATA),
    .par_typ (bus.PAR_TYP),
    .par     (par_nxt)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      par_q <= 1'b0;
    end else if (capture) begin
      par_q <= par_nxt;
    end
  end

  assign bus.par_bit = par_q;
`else
  logic unused_par_typ;
  assign unused_par_typ = bus.PAR_TYP;
  assign bus.par_bit    = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed + randomized frame checks of uart_tx_serializer.
module tb_uart_tx_serializer;
  import uart_pkg::*;

  logic CLK;
  logic RST;
  int   n_cmp;
  int   n_bad;

  uart_tx_serializer_if #(.DATA_WIDTH(8)) bus ();

  uart_tx_serializer #(
    .DATA_WIDTH (8)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic exp_par(input logic [7:0] d, input logic pt);
`ifdef UART_TX_PARITY_EN
    int ones;
    ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(d[i]);
    return ((ones % 2) == 1) ^ (pt == PAR_ODD);
`else
    return 1'b0 & d[0] & pt;
`endif
  endfunction

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  // One FSM-style frame: capture, STR, 8 data, extra enables, parity, stop.
  task automatic run_frame(input logic [7:0] d, input logic pt,
                           input int extra, input int ign_k,
                           input int abort_k);
    logic ep;
    ep = exp_par(d, pt);
    bus.P_DATA     = d;
    bus.PAR_TYP    = pt;
    bus.DATA_VALID = 1'b1;
    bus.Busy       = 1'b0;
    bus.ser_en     = 1'b0;
    tick;
    bus.DATA_VALID = 1'b0;
    bus.Busy       = 1'b1;
    bus.P_DATA     = 8'($urandom);
    bus.PAR_TYP    = 1'($urandom);
    chk("str_done", bus.ser_done, 1'b0);
    chk("str_par", bus.par_bit, ep);
    bus.ser_en = 1'b1;
    tick;
    for (int k = 1; k <= 8; k++) begin
      if (k == abort_k) begin
        RST = 1'b0;
        #1;
        chk("rst_done", bus.ser_done, 1'b1);
        chk("rst_data", bus.ser_data, 1'b0);
        chk("rst_par", bus.par_bit, 1'b0);
        bus.ser_en = 1'b0;
        bus.Busy   = 1'b0;
        #2;
        RST = 1'b1;
        return;
      end
      chk("data", bus.ser_data, d[k-1]);
      chk("done", bus.ser_done, k == 8);
      chk("par", bus.par_bit, ep);
      bus.DATA_VALID = (k == ign_k);
      if (k == ign_k) begin
        bus.P_DATA  = 8'hFF;
        bus.PAR_TYP = ~pt;
      end
      bus.ser_en = (k < 8);
      tick;
    end
    bus.DATA_VALID = 1'b0;
    for (int j = 0; j < extra + 2; j++) begin
      chk("hold_data", bus.ser_data, d[7]);
      chk("hold_done", bus.ser_done, 1'b1);
      chk("hold_par", bus.par_bit, ep);
      bus.ser_en = (j < extra);
      tick;
    end
    bus.Busy   = 1'b0;
    bus.ser_en = 1'b0;
  endtask

  initial begin
    logic [7:0] rd;
    logic       rp;
    n_cmp          = 0;
    n_bad          = 0;
    RST            = 1'b0;
    bus.P_DATA     = '0;
    bus.DATA_VALID = 1'b0;
    bus.Busy       = 1'b0;
    bus.ser_en     = 1'b0;
    bus.PAR_TYP    = 1'b0;
    #12;
    chk("reset_done", bus.ser_done, 1'b1);
    chk("reset_data", bus.ser_data, 1'b0);
    chk("reset_par", bus.par_bit, 1'b0);
    RST = 1'b1;
    tick;

    run_frame(8'hA5, PAR_EVEN, 0, 0, 0);
    run_frame(8'h80, PAR_ODD, 0, 0, 0);
    run_frame(8'h80, PAR_EVEN, 0, 0, 0);
    run_frame(8'h3C, PAR_EVEN, 0, 3, 0);
    run_frame(8'h3C, PAR_ODD, 3, 0, 0);
    run_frame(8'hA5, PAR_ODD, 0, 0, 5);
    tick;
    run_frame(8'h01, PAR_EVEN, 0, 0, 0);
    run_frame(8'h07, PAR_EVEN, 0, 0, 0);
    run_frame(8'h07, PAR_ODD, 0, 0, 0);

    for (int i = 0; i < 24; i++) begin
      rd = 8'($urandom);
      rp = 1'($urandom);
      run_frame(rd, rp, int'($urandom_range(0, 3)),
                int'($urandom_range(0, 8)), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
